pi_bus_master: RTL and testbench

- Downstream consumer of the clk16 slot generator's pi_select/pi_strobe outputs.
- Accepts one SRAM read or write request at a time from the Pi-side interface.
- Holds the request until the next complete Pi slot, then drives the SRAM address, data and strobes only inside pi_strobe.
- Returns read data with a one-cycle done pulse. A later bus mux uses bus_en to choose between this block and the CPU.

---
 rtl/pi_bus_master_pkg.sv | 20 ++
 rtl/pi_bus_master.sv | 85 ++++++++
 tb/tb_pi_bus_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pi_bus_master_pkg.sv
// Shared definitions for the SRAM bus masters and the bus mux: state encoding
// and default bus widths.
package pi_bus_master_pkg;

    localparam int PI_ADDR_WIDTH = 17;
    localparam int PI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ARMED  = 2'd2,
        ACCESS = 2'd3
    } bus_state_t;

    // A master may own the bus only once it is lined up on a slot.
    function automatic logic owns_slot(input bus_state_t st);
        return (st == ARMED) || (st == ACCESS);
    endfunction

endpackage

// File: rtl/pi_bus_master.sv
// Pi-side SRAM bus master: holds one request until the next full Pi slot and
// drives the SRAM strobes only inside pi_strobe.
module pi_bus_master
    import pi_bus_master_pkg::*;
#(
    parameter int ADDR_WIDTH = PI_ADDR_WIDTH,
    parameter int DATA_WIDTH = PI_DATA_WIDTH
) (
    input  logic                  clk16,
    input  logic                  reset,
    input  logic                  pi_select,
    input  logic                  pi_strobe,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_we,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  bus_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_dout_oe,
    input  logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we_n,
    output logic                  ram_oe_n
);

    bus_state_t state;
    logic       we_q;

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            done      <= 1'b0;
            rd_data   <= '0;
            ram_addr  <= '0;
            ram_dout  <= '0;
            we_q      <= 1'b0;
        end else begin
            done <= 1'b0;
            // Every read strobe cycle overwrites, so the last one wins.
            if (owns_slot(state) && pi_strobe && !we_q)
                rd_data <= ram_din;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ram_addr  <= req_addr;
                        ram_dout  <= req_data;
                        we_q      <= req_we;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Arming only before the strobe means we never join one midway.
                    if (pi_select && !pi_strobe)
                        state <= ARMED;
                end
                ARMED: begin
                    if (pi_strobe)
                        state <= ACCESS;
                    else if (!pi_select)
                        state <= WAIT;
                end
                ACCESS: begin
                    if (!pi_strobe) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // State resets asynchronously, so the strobes drop as soon as reset rises.
    assign bus_en      = pi_select & owns_slot(state);
    assign ram_we_n    = ~(bus_en & pi_strobe & we_q);
    assign ram_oe_n    = ~(bus_en & pi_strobe & ~we_q);
    assign ram_dout_oe = bus_en & we_q;

endmodule

// File: tb/tb_pi_bus_master.sv
// Directed bench for pi_bus_master with an inline 16-cycle slot generator
// (select at counts 0..3, strobe at counts 2..3) and a byte-wide SRAM model.
module tb_pi_bus_master;
    import pi_bus_master_pkg::*;

    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk16 = 1'b0;
    logic          reset;
    logic [3:0]    cnt = 4'd0;
    logic          pi_select, pi_strobe;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [DW-1:0] rd_data;
    logic          done, bus_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout, ram_din;
    logic          ram_dout_oe, ram_we_n, ram_oe_n;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_tests = 0;
    int n_fail  = 0;

    pi_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk16(clk16), .reset(reset),
        .pi_select(pi_select), .pi_strobe(pi_strobe),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_we(req_we),
        .rd_data(rd_data), .done(done), .bus_en(bus_en),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_dout_oe(ram_dout_oe),
        .ram_din(ram_din), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
    );

    always #5 clk16 = ~clk16;

    always @(posedge clk16) cnt <= cnt + 4'd1;
    assign pi_select = (cnt < 4'd4);
    assign pi_strobe = (cnt == 4'd2) || (cnt == 4'd3);

    always @(posedge clk16) begin
        if (reset)
            mem[17'h00042] <= 8'hC3;
        else if (!ram_we_n)
            mem[ram_addr] <= ram_dout;
    end
    assign ram_din = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request during the cycle whose slot count equals start.
    task automatic send(input int start, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        for (int k = 0; k < 32; k++) begin
            @(posedge clk16); #1;
            if (cnt == start[3:0]) break;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_data  = d;
        @(posedge clk16); #1;
        req_valid = 1'b0;
    endtask

    // Follow one access up to its done pulse; n is the cycle index of done (0 = timeout).
    task automatic watch(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int n, output int lo, output int bad, output int cd);
        n = 0; lo = 0; bad = 0; cd = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk16);
            if (!ram_we_n || !ram_oe_n) begin
                lo++;
                if (!pi_strobe || ram_addr != a) bad++;
                if (we && (!ram_oe_n || ram_dout != d)) bad++;
                if (!we && !ram_we_n) bad++;
            end
            if (ram_dout_oe != (we && bus_en)) bad++;
            if (done) begin
                n  = k;
                cd = int'(cnt);
                if (!req_ready) bad++;
                break;
            end
            if (req_ready) bad++;
        end
    endtask

    int n, lo, bad, cd;
    int ndone, last, gap_bad, busy_bad, sel_bad, idx, soak_bad;
    bit busy, acc;
    int starts [5] = '{0, 2, 3, 5, 9};
    int lats   [5] = '{5, 19, 18, 16, 12};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
        repeat (3) @(posedge clk16);
        @(negedge clk16);
        chk("rst_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_dout", ram_dout, 0);
        chk("rst_strobes", {bus_en, ram_dout_oe, ram_we_n, ram_oe_n}, 4'b0011);
        reset = 1'b0;

        // Write requested at count 5 lands in the next frame's strobe.
        send(5, 1'b1, 17'h1ABCD, 8'h5A);
        watch(1'b1, 17'h1ABCD, 8'h5A, n, lo, bad, cd);
        chk("wr_latency", n, 16);
        chk("wr_done_cnt", cd, 5);
        chk("wr_we_cycles", lo, 2);
        chk("wr_bad", bad, 0);
        chk("wr_mem", mem[17'h1ABCD], 8'h5A);

        send(9, 1'b0, 17'h00042, 8'h00);
        watch(1'b0, 17'h00042, 8'h00, n, lo, bad, cd);
        chk("rd_latency", n, 12);
        chk("rd_oe_cycles", lo, 2);
        chk("rd_bad", bad, 0);
        chk("rd_data", rd_data, 8'hC3);

        send(0, 1'b1, 17'h00100, 8'h77);
        watch(1'b1, 17'h00100, 8'h77, n, lo, bad, cd);
        chk("wr2_latency", n, 5);
        chk("wr2_bad", bad, 0);
        chk("wr2_mem", mem[17'h00100], 8'h77);
        chk("wr2_rd_hold", rd_data, 8'hC3);

        // Latency versus frame phase; counts 2 and 3 miss the current strobe.
        for (int i = 0; i < 5; i++) begin
            send(starts[i], 1'b0, 17'h00042, 8'h00);
            watch(1'b0, 17'h00042, 8'h00, n, lo, bad, cd);
            chk($sformatf("phase%0d_latency", starts[i]), n, lats[i]);
            chk($sformatf("phase%0d_done_cnt", starts[i]), cd, 5);
            chk($sformatf("phase%0d_oe_cycles", starts[i]), lo, 2);
            chk($sformatf("phase%0d_bad", starts[i]), bad, 0);
        end

        // Back-to-back writes with req_valid held high.
        for (int k = 0; k < 32; k++) begin
            @(posedge clk16); #1;
            if (cnt == 4'd0) break;
        end
        ndone = 0; last = -1; gap_bad = 0; busy_bad = 0; sel_bad = 0; idx = 0; busy = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 17'h00200; req_data = 8'h11;
        for (int k = 0; k < 100 && ndone < 4; k++) begin
            @(negedge clk16);
            acc = req_valid && req_ready;
            if ((!ram_we_n || !ram_oe_n || bus_en) && !pi_select) sel_bad++;
            if (busy && !done && req_ready) busy_bad++;
            if (done) begin
                if (last >= 0 && k - last != 16) gap_bad++;
                last = k;
                ndone++;
                busy = 0;
            end
            @(posedge clk16); #1;
            if (acc) begin
                busy = 1;
                idx++;
                if (idx == 4) req_valid = 1'b0;
                else begin
                    req_addr = 17'h00200 + 17'(idx);
                    req_data = 8'h11 + 8'(idx);
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_done_count", ndone, 4);
        chk("b2b_gap", gap_bad, 0);
        chk("b2b_ready_busy", busy_bad, 0);
        chk("b2b_outside_select", sel_bad, 0);
        chk("b2b_mem0", mem[17'h00200], 8'h11);
        chk("b2b_mem3", mem[17'h00203], 8'h14);

        // Reset pulse in the middle of a write strobe.
        send(5, 1'b1, 17'h00300, 8'h99);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk16);
            if (cnt == 4'd3) break;
        end
        chk("rst_mid_we_active", ram_we_n, 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_we_n", ram_we_n, 1);
        chk("rst_mid_bus_en", bus_en, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_rd_data", rd_data, 0);
        @(posedge clk16);
        @(negedge clk16);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk16);
            if (done) ndone++;
        end
        chk("rst_mid_no_done", ndone, 0);
        send(0, 1'b0, 17'h00042, 8'h00);
        watch(1'b0, 17'h00042, 8'h00, n, lo, bad, cd);
        chk("post_rst_latency", n, 5);
        chk("post_rst_bad", bad, 0);
        chk("post_rst_rd_data", rd_data, 8'hC3);

        soak_bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk16);
            if (bus_en || !ram_we_n || !ram_oe_n || done) soak_bad++;
        end
        chk("idle_soak", soak_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
